ec_point_dbl_add_arb: RTL

- Shares one point doubler and one point adder between NUM_REQ point-multiplier engines (ec_point_mult instances).
- Each engine sees a private dbl/add request/response pair, so several scalar multiplications run in parallel on one arithmetic core pair.
- Requests are round-robin arbitrated per channel and tagged with the requester index in ctl. Responses are routed back by that tag.
- The doubler and adder must return ctl unchanged.

---
 rtl/ec_pkg.sv | 24 ++
 rtl/ec_rr_chan_arb.sv | 178 +++++++++++++++++
 rtl/ec_point_dbl_add_arb.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ec_pkg.sv
// Shared helpers for the point doubler/adder arbiter: index widths and
// round-robin pointer arithmetic.
package ec_pkg;

    // Bit positions inside the sticky tag-error vector.
    localparam int ERR_DBL_BIT = 0;
    localparam int ERR_ADD_BIT = 1;

    // Width of the requester tag carried in the low ctl bits.
    function automatic int idx_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold values 0..m inclusive.
    function automatic int cnt_bits(input int m);
        return (m <= 1) ? 1 : $clog2(m + 1);
    endfunction

    // Requester index after idx, wrapping modulo n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ec_rr_chan_arb.sv
// One shared-core channel: round-robin request arbiter with a registered
// output stage, an outstanding-operation counter and a tag-based response demux.
//
// Handshake: a beat transfers on a rising clock edge where val and rdy are
// both high. A source never lowers val (or changes its payload) while val is
// high and rdy is low; rdy may depend combinationally on val.
module ec_rr_chan_arb
    import ec_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DAT_BITS     = 32,
    parameter int CTL_BITS     = 8,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    // requester side, requests in
    input  logic [NUM_REQ-1:0]                 i_req_val,
    output logic [NUM_REQ-1:0]                 o_req_rdy,
    input  logic [NUM_REQ-1:0][DAT_BITS-1:0]   i_req_dat,
    input  logic [NUM_REQ-1:0][CTL_BITS-1:0]   i_req_ctl,
    input  logic [NUM_REQ-1:0]                 i_req_err,
    // requester side, responses out
    output logic [NUM_REQ-1:0]                 o_rsp_val,
    input  logic [NUM_REQ-1:0]                 i_rsp_rdy,
    output logic [NUM_REQ-1:0][DAT_BITS-1:0]   o_rsp_dat,
    output logic [NUM_REQ-1:0][CTL_BITS-1:0]   o_rsp_ctl,
    output logic [NUM_REQ-1:0]                 o_rsp_err,
    // shared core, requests out
    output logic                               o_core_val,
    input  logic                               i_core_rdy,
    output logic [DAT_BITS-1:0]                o_core_dat,
    output logic [CTL_BITS-1:0]                o_core_ctl,
    output logic                               o_core_err,
    // shared core, results in
    input  logic                               i_core_val,
    output logic                               o_core_rdy,
    input  logic [DAT_BITS-1:0]                i_core_dat,
    input  logic [CTL_BITS-1:0]                i_core_ctl,
    input  logic                               i_core_err,
    // sticky flag: a result came back with a tag no requester owns
    output logic                               o_tag_err
);

    localparam int IDX_BITS = idx_bits(NUM_REQ);
    localparam int CNT_BITS = cnt_bits(MAX_INFLIGHT);

    logic                core_val_q, core_val_d;
    logic [DAT_BITS-1:0] core_dat_q, core_dat_d;
    logic [CTL_BITS-1:0] core_ctl_q, core_ctl_d;
    logic                core_err_q, core_err_d;
    logic [IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_BITS-1:0] inflight_q, inflight_d;
    logic                tag_err_q, tag_err_d;

    logic                can_grant;
    logic                found;
    logic                issue;
    logic                retire;
    logic                tag_ok;
    logic [IDX_BITS-1:0] gnt_idx;
    logic [IDX_BITS-1:0] rsp_tag;
    logic [DAT_BITS-1:0] sel_dat;
    logic [CTL_BITS-1:0] sel_ctl;
    logic                sel_err;

    // Pick the first valid requester at or above rr_ptr, else the first below it.
    always_comb begin
        found     = 1'b0;
        gnt_idx   = '0;
        o_req_rdy = '0;
        sel_dat   = '0;
        sel_ctl   = '0;
        sel_err   = 1'b0;
        can_grant = !i_rst && (!core_val_q || i_core_rdy) &&
                    (inflight_q < CNT_BITS'(MAX_INFLIGHT));
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && i_req_val[j] && (IDX_BITS'(j) >= rr_ptr_q)) begin
                found   = 1'b1;
                gnt_idx = IDX_BITS'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && i_req_val[j]) begin
                found   = 1'b1;
                gnt_idx = IDX_BITS'(j);
            end
        end
        issue = can_grant && found;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt_idx == IDX_BITS'(j)) begin
                o_req_rdy[j] = issue;
                sel_dat      = i_req_dat[j];
                sel_ctl      = i_req_ctl[j];
                sel_err      = i_req_err[j];
            end
        end
    end

    // Route a core result to the requester named by its tag; unknown tags are swallowed.
    always_comb begin
        rsp_tag    = i_core_ctl[IDX_BITS-1:0];
        tag_ok     = 1'b0;
        o_core_rdy = 1'b1;
        o_rsp_val  = '0;
        o_rsp_dat  = '0;
        o_rsp_ctl  = '0;
        o_rsp_err  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (rsp_tag == IDX_BITS'(j)) begin
                tag_ok       = 1'b1;
                o_core_rdy   = i_rsp_rdy[j];
                o_rsp_val[j] = i_core_val;
                if (i_core_val) begin
                    o_rsp_dat[j]                 = i_core_dat;
                    o_rsp_ctl[j]                 = i_core_ctl;
                    o_rsp_ctl[j][IDX_BITS-1:0]   = '0;
                    o_rsp_err[j]                 = i_core_err;
                end
            end
        end
        retire = i_core_val && o_core_rdy;
    end

    // Next state of the output register, arbiter pointer and outstanding count.
    always_comb begin
        core_val_d = core_val_q;
        core_dat_d = core_dat_q;
        core_ctl_d = core_ctl_q;
        core_err_d = core_err_q;
        rr_ptr_d   = rr_ptr_q;
        inflight_d = inflight_q;
        tag_err_d  = tag_err_q | (i_core_val && !tag_ok);
        if (issue) begin
            core_val_d                 = 1'b1;
            core_dat_d                 = sel_dat;
            core_ctl_d                 = sel_ctl;
            core_ctl_d[IDX_BITS-1:0]   = gnt_idx;
            core_err_d                 = sel_err;
            rr_ptr_d                   = IDX_BITS'(rr_next(int'(gnt_idx), NUM_REQ));
        end else if (i_core_rdy) begin
            core_val_d = 1'b0;
        end
        case ({issue, retire})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            core_val_q <= 1'b0;
            core_dat_q <= '0;
            core_ctl_q <= '0;
            core_err_q <= 1'b0;
            rr_ptr_q   <= '0;
            inflight_q <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            core_val_q <= core_val_d;
            core_dat_q <= core_dat_d;
            core_ctl_q <= core_ctl_d;
            core_err_q <= core_err_d;
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
            tag_err_q  <= tag_err_d;
        end
    end

    assign o_core_val = core_val_q;
    assign o_core_dat = core_dat_q;
    assign o_core_ctl = core_ctl_q;
    assign o_core_err = core_err_q;
    assign o_tag_err  = tag_err_q;

endmodule

// File: rtl/ec_point_dbl_add_arb.sv
// Shares one point doubler and one point adder between NUM_REQ point
// multiplier engines. Each engine owns a private dbl and add stream pair;
// the two channels are independent. Every transfer is a single-beat packet,
// so sop/eop are held high on all outgoing streams.
module ec_point_dbl_add_arb
    import ec_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int FP_BITS      = 32,
    parameter int CTL_BITS     = 8,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    // double requests from engines
    input  logic [NUM_REQ-1:0]                  i_dbl_req_val,
    output logic [NUM_REQ-1:0]                  i_dbl_req_rdy,
    input  logic [NUM_REQ-1:0][FP_BITS-1:0]     i_dbl_req_dat,
    input  logic [NUM_REQ-1:0][CTL_BITS-1:0]    i_dbl_req_ctl,
    input  logic [NUM_REQ-1:0]                  i_dbl_req_err,
    // double results to engines
    output logic [NUM_REQ-1:0]                  o_dbl_rsp_val,
    input  logic [NUM_REQ-1:0]                  o_dbl_rsp_rdy,
    output logic [NUM_REQ-1:0][FP_BITS-1:0]     o_dbl_rsp_dat,
    output logic [NUM_REQ-1:0][CTL_BITS-1:0]    o_dbl_rsp_ctl,
    output logic [NUM_REQ-1:0]                  o_dbl_rsp_err,
    output logic [NUM_REQ-1:0]                  o_dbl_rsp_sop,
    output logic [NUM_REQ-1:0]                  o_dbl_rsp_eop,
    // add requests from engines
    input  logic [NUM_REQ-1:0]                  i_add_req_val,
    output logic [NUM_REQ-1:0]                  i_add_req_rdy,
    input  logic [NUM_REQ-1:0][2*FP_BITS-1:0]   i_add_req_dat,
    input  logic [NUM_REQ-1:0][CTL_BITS-1:0]    i_add_req_ctl,
    input  logic [NUM_REQ-1:0]                  i_add_req_err,
    // add results to engines
    output logic [NUM_REQ-1:0]                  o_add_rsp_val,
    input  logic [NUM_REQ-1:0]                  o_add_rsp_rdy,
    output logic [NUM_REQ-1:0][2*FP_BITS-1:0]   o_add_rsp_dat,
    output logic [NUM_REQ-1:0][CTL_BITS-1:0]    o_add_rsp_ctl,
    output logic [NUM_REQ-1:0]                  o_add_rsp_err,
    output logic [NUM_REQ-1:0]                  o_add_rsp_sop,
    output logic [NUM_REQ-1:0]                  o_add_rsp_eop,
    // to shared doubler
    output logic                                o_dbl_val,
    input  logic                                o_dbl_rdy,
    output logic [FP_BITS-1:0]                  o_dbl_dat,
    output logic [CTL_BITS-1:0]                 o_dbl_ctl,
    output logic                                o_dbl_err,
    output logic                                o_dbl_sop,
    output logic                                o_dbl_eop,
    // from shared doubler
    input  logic                                i_dbl_val,
    output logic                                i_dbl_rdy,
    input  logic [FP_BITS-1:0]                  i_dbl_dat,
    input  logic [CTL_BITS-1:0]                 i_dbl_ctl,
    input  logic                                i_dbl_err,
    // to shared adder
    output logic                                o_add_val,
    input  logic                                o_add_rdy,
    output logic [2*FP_BITS-1:0]                o_add_dat,
    output logic [CTL_BITS-1:0]                 o_add_ctl,
    output logic                                o_add_err,
    output logic                                o_add_sop,
    output logic                                o_add_eop,
    // from shared adder
    input  logic                                i_add_val,
    output logic                                i_add_rdy,
    input  logic [2*FP_BITS-1:0]                i_add_dat,
    input  logic [CTL_BITS-1:0]                 i_add_ctl,
    input  logic                                i_add_err,
    // bit0 dbl tag error, bit1 add tag error
    output logic [1:0]                          o_err_sticky
);

    logic dbl_tag_err;
    logic add_tag_err;

    ec_rr_chan_arb #(
        .NUM_REQ      (NUM_REQ),
        .DAT_BITS     (FP_BITS),
        .CTL_BITS     (CTL_BITS),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_dbl_chan (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req_val  (i_dbl_req_val),
        .o_req_rdy  (i_dbl_req_rdy),
        .i_req_dat  (i_dbl_req_dat),
        .i_req_ctl  (i_dbl_req_ctl),
        .i_req_err  (i_dbl_req_err),
        .o_rsp_val  (o_dbl_rsp_val),
        .i_rsp_rdy  (o_dbl_rsp_rdy),
        .o_rsp_dat  (o_dbl_rsp_dat),
        .o_rsp_ctl  (o_dbl_rsp_ctl),
        .o_rsp_err  (o_dbl_rsp_err),
        .o_core_val (o_dbl_val),
        .i_core_rdy (o_dbl_rdy),
        .o_core_dat (o_dbl_dat),
        .o_core_ctl (o_dbl_ctl),
        .o_core_err (o_dbl_err),
        .i_core_val (i_dbl_val),
        .o_core_rdy (i_dbl_rdy),
        .i_core_dat (i_dbl_dat),
        .i_core_ctl (i_dbl_ctl),
        .i_core_err (i_dbl_err),
        .o_tag_err  (dbl_tag_err)
    );

    ec_rr_chan_arb #(
        .NUM_REQ      (NUM_REQ),
        .DAT_BITS     (2*FP_BITS),
        .CTL_BITS     (CTL_BITS),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_add_chan (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req_val  (i_add_req_val),
        .o_req_rdy  (i_add_req_rdy),
        .i_req_dat  (i_add_req_dat),
        .i_req_ctl  (i_add_req_ctl),
        .i_req_err  (i_add_req_err),
        .o_rsp_val  (o_add_rsp_val),
        .i_rsp_rdy  (o_add_rsp_rdy),
        .o_rsp_dat  (o_add_rsp_dat),
        .o_rsp_ctl  (o_add_rsp_ctl),
        .o_rsp_err  (o_add_rsp_err),
        .o_core_val (o_add_val),
        .i_core_rdy (o_add_rdy),
        .o_core_dat (o_add_dat),
        .o_core_ctl (o_add_ctl),
        .o_core_err (o_add_err),
        .i_core_val (i_add_val),
        .o_core_rdy (i_add_rdy),
        .i_core_dat (i_add_dat),
        .i_core_ctl (i_add_ctl),
        .i_core_err (i_add_err),
        .o_tag_err  (add_tag_err)
    );

    assign o_dbl_sop     = 1'b1;
    assign o_dbl_eop     = 1'b1;
    assign o_add_sop     = 1'b1;
    assign o_add_eop     = 1'b1;
    assign o_dbl_rsp_sop = '1;
    assign o_dbl_rsp_eop = '1;
    assign o_add_rsp_sop = '1;
    assign o_add_rsp_eop = '1;

    always_comb begin
        o_err_sticky              = '0;
        o_err_sticky[ERR_DBL_BIT] = dbl_tag_err;
        o_err_sticky[ERR_ADD_BIT] = add_tag_err;
    end

endmodule
